// File: rtl/up_counter_ctrl.sv
// Run controller sequencing a WIDTH-bit up counter through counting periods.
// Optional build macro CNT_PRESCALE_EN divides the count rate by PRESCALE.
module up_counter_ctrl #(
    parameter int WIDTH    = 3,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic [3:0]       run_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             done_q, done_d;
    logic [3:0]       run_cnt_q, run_cnt_d;
    logic             tick;
    logic             pre_adv;
    logic             pre_clr;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        done_d    = 1'b0;
        run_cnt_d = run_cnt_q;
        pre_adv   = 1'b0;
        pre_clr   = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            count_d = '0;
            pre_clr = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d   = S_RUN;
                        count_d   = '0;
                        limit_d   = limit;
                        run_cnt_d = 4'd0;
                        pre_clr   = 1'b1;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_HOLD;
                    end else begin
                        pre_adv = 1'b1;
                        if (tick) begin
                            if (count_q != limit_q) begin
                                count_d = count_q + WIDTH'(1);
                            end else begin
                                done_d = 1'b1;
                                if (run_cnt_q != 4'd15) begin
                                    run_cnt_d = run_cnt_q + 4'd1;
                                end
                                // Reload wraps to zero; the counter never overflows.
                                if (auto_reload) begin
                                    count_d = '0;
                                end else begin
                                    state_d = S_DONE;
                                end
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef CNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (pre_clr) begin
            pre_d = '0;
        end else if (pre_adv) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    localparam int UNUSED_PRESCALE = PRESCALE;
    logic unused_pre;

    assign tick       = 1'b1;
    assign unused_pre = pre_adv ^ pre_clr;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            done_q    <= 1'b0;
            run_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            done_q    <= done_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign count   = count_q;
    assign busy    = (state_q == S_RUN) || (state_q == S_HOLD);
    assign paused  = (state_q == S_HOLD);
    assign done    = done_q;
    assign run_cnt = run_cnt_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Self-checking bench for up_counter_ctrl: vector table, corner sequences
// and randomized traffic against a reference model.
module tb_up_counter_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic       auto_reload;
    logic [2:0] limit;
    logic [2:0] count;
    logic       busy;
    logic       paused;
    logic       done;
    logic [3:0] run_cnt;

    int checks = 0;
    int errors = 0;

    up_counter_ctrl #(.WIDTH(3), .PRESCALE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .auto_reload(auto_reload),
        .limit      (limit),
        .count      (count),
        .busy       (busy),
        .paused     (paused),
        .done       (done),
        .run_cnt    (run_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       pause;
        logic       ar;
        logic [2:0] lim;
        int         e_cnt;
        int         e_busy;
        int         e_paused;
        int         e_done;
        int         e_rc;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int b,
                           input int p, input int d, input int r);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".paused"}, int'(paused), p);
        chk({tag, ".done"}, int'(done), d);
        chk({tag, ".run_cnt"}, int'(run_cnt), r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic sp, input logic p,
                         input logic a, input logic [2:0] l);
        start       = s;
        stop        = sp;
        pause       = p;
        auto_reload = a;
        limit       = l;
    endtask

    function automatic vec_t mk(input logic s, input logic sp, input logic p,
                                input logic a, input logic [2:0] l,
                                input int c, input int b, input int pz,
                                input int d, input int r);
        vec_t v;
        v.start = s; v.stop = sp; v.pause = p; v.ar = a; v.lim = l;
        v.e_cnt = c; v.e_busy = b; v.e_paused = pz; v.e_done = d; v.e_rc = r;
        return v;
    endfunction

    // Reference model: mode 0 idle, 1 counting, 2 held, 3 finished.
    int m_mode, m_cnt, m_lim, m_rc, m_done;

    task automatic model_step(input logic r, input logic s, input logic sp,
                              input logic p, input logic a, input int l);
        m_done = 0;
        if (!r) begin
            m_mode = 0; m_cnt = 0; m_lim = 0; m_rc = 0;
        end else if (sp) begin
            m_mode = 0; m_cnt = 0;
        end else if (m_mode == 0 || m_mode == 3) begin
            if (s) begin
                m_mode = 1; m_cnt = 0; m_lim = l; m_rc = 0;
            end
        end else if (m_mode == 2) begin
            if (!p) m_mode = 1;
        end else if (p) begin
            m_mode = 2;
        end else if (m_cnt < m_lim) begin
            m_cnt = m_cnt + 1;
        end else begin
            m_done = 1;
            m_rc = (m_rc >= 15) ? 15 : m_rc + 1;
            if (a) m_cnt = 0;
            else m_mode = 3;
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 3'd0);

        tbl[0]  = mk(1, 0, 0, 0, 3'd5, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 3'd5, 1, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 3'd2, 2, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 3'd2, 3, 1, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 3'd2, 4, 1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 3'd2, 5, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 3'd2, 5, 0, 0, 1, 1);
        tbl[7]  = mk(0, 0, 0, 0, 3'd2, 5, 0, 0, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0, 3'd6, 0, 1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 3'd6, 1, 1, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 3'd6, 2, 1, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 0, 3'd6, 2, 1, 1, 0, 0);
        tbl[12] = mk(0, 0, 1, 0, 3'd6, 2, 1, 1, 0, 0);
        tbl[13] = mk(0, 0, 1, 0, 3'd6, 2, 1, 1, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 3'd6, 2, 1, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 3'd6, 3, 1, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 3'd6, 4, 1, 0, 0, 0);
        tbl[17] = mk(0, 1, 0, 0, 3'd6, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 1, 0, 0, 3'd6, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 0, 0, 1, 3'd0, 0, 1, 0, 0, 0);
        tbl[20] = mk(0, 0, 0, 1, 3'd0, 0, 1, 0, 1, 1);
        tbl[21] = mk(0, 0, 0, 1, 3'd0, 0, 1, 0, 1, 2);
        tbl[22] = mk(0, 0, 0, 1, 3'd0, 0, 1, 0, 1, 3);
        tbl[23] = mk(0, 1, 0, 1, 3'd0, 0, 0, 0, 0, 3);

        // Power-on reset
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].start, tbl[i].stop, tbl[i].pause, tbl[i].ar, tbl[i].lim);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_busy,
                    tbl[i].e_paused, tbl[i].e_done, tbl[i].e_rc);
        end

        // Reset in the middle of a run
        drive(1, 0, 0, 1, 3'd7);
        step();
        drive(0, 0, 0, 1, 3'd7);
        for (int i = 0; i < 3; i++) step();
        chk("midrun.count", int'(count), 3);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_all($sformatf("midrst%0d", i), 0, 0, 0, 0, 0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("postrst%0d", i), 0, 0, 0, 0, 0);
        end

        // Auto-reload at all-ones limit, then run_cnt saturation
        drive(1, 0, 0, 1, 3'd7);
        step();
        chk_all("ar.start", 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 3'd7);
        for (int k = 1; k <= 136; k++) begin
            step();
            if (k <= 24) begin
                chk_all($sformatf("ar%0d", k), k % 8, 1, 0,
                        (k % 8 == 0) ? 1 : 0, k / 8);
            end else if (k == 120 || k == 128 || k == 136) begin
                chk($sformatf("ar%0d.run_cnt", k), int'(run_cnt), 15);
            end
        end
        drive(0, 1, 0, 0, 3'd0);
        step();
        chk_all("ar.stop", 0, 0, 0, 0, 15);

        // Randomized traffic against the reference model
        rst = 1'b0;
        drive(0, 0, 0, 0, 3'd0);
        model_step(0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic r, s, sp, p, a;
            logic [2:0] l;
            r  = ($urandom_range(0, 99) != 0);
            s  = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 19) == 0);
            p  = ($urandom_range(0, 5) == 0);
            a  = $urandom_range(0, 1) != 0;
            l  = 3'($urandom_range(0, 7));
            rst = r;
            drive(s, sp, p, a, l);
            model_step(r, s, sp, p, a, int'(l));
            step();
            chk_all($sformatf("rnd%0d", i), m_cnt,
                    (m_mode == 1 || m_mode == 2) ? 1 : 0,
                    (m_mode == 2) ? 1 : 0, m_done, m_rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
